// File: rtl/bus_scratch_slv.sv
// bus_scratch_slv: scratch RAM plus CSR bank behind the simplified AXI
// interconnect, answering reads after a programmable number of wait states.
//
// Ports:
//   clk                 system clock
//   arstn               asynchronous active-low reset
//   c_axi_mst_wr_valid  single-cycle write request
//   axi_mst_wr_addr     write byte address
//   axi_mst_wr_data     write data
//   c_axi_mst_rd_valid  single-cycle read request
//   axi_mst_rd_addr     read byte address
//   c_axi_slv_rd_ready  one-cycle read-response strobe
//   axi_slv_rd_data     read data, valid with the strobe and then held
//   c_busy              a read is outstanding
//
// Window: 2*DEPTH words at ADDR_BASE. Lower DEPTH words are RAM, upper DEPTH
// words are CSRs: 0 WAIT (RW, [3:0]), 1 WR_CNT, 2 RD_CNT, 3 ID, others read 0.
//
// Optional build macro BUS_SCRATCH_SLV_DROP_CNT_EN adds CSR 4 DROP_CNT, which
// counts reads dropped while busy; any write to offset 4 clears it.
//
// Read FSM:
//   state   | meaning
//   IDLE    | ready to accept a read
//   WAITING | read captured, counting down wait states
//   RESP    | response strobe is high this cycle

module bus_scratch_slv #(
   parameter int          DEPTH     = 256,
   parameter int          AW        = 8,
   parameter logic [31:0] ADDR_BASE = 32'h0004_0000,
   parameter logic [3:0]  WAIT_RST  = 4'd1,
   parameter logic [31:0] ID_VAL    = 32'h5C7A_0001
) (
   input  logic        clk,
   input  logic        arstn,
   input  logic        c_axi_mst_wr_valid,
   input  logic [31:0] axi_mst_wr_addr,
   input  logic [31:0] axi_mst_wr_data,
   input  logic        c_axi_mst_rd_valid,
   input  logic [31:0] axi_mst_rd_addr,
   output logic        c_axi_slv_rd_ready,
   output logic [31:0] axi_slv_rd_data,
   output logic        c_busy
);

   typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [3:0]  wait_q;
   logic [31:0] wr_cnt_q;
   logic [31:0] rd_cnt_q;
   logic [31:0] hold_q;
   logic [31:0] mem [DEPTH];

   logic          wr_hit, rd_hit, wr_csr, rd_csr;
   logic [AW-1:0] wr_idx, rd_idx;
   logic [31:0]   csr_rd, rd_val;
   logic          unused_addr_lsb;

   // byte lanes are not modelled; the two address LSBs are don't-care
   assign unused_addr_lsb = ^{axi_mst_wr_addr[1:0], axi_mst_rd_addr[1:0]};

   assign wr_hit = c_axi_mst_wr_valid && (axi_mst_wr_addr[31:AW+3] == ADDR_BASE[31:AW+3]);
   assign rd_hit = c_axi_mst_rd_valid && (axi_mst_rd_addr[31:AW+3] == ADDR_BASE[31:AW+3]);
   assign wr_csr = axi_mst_wr_addr[AW+2];
   assign rd_csr = axi_mst_rd_addr[AW+2];
   assign wr_idx = axi_mst_wr_addr[AW+1:2];
   assign rd_idx = axi_mst_rd_addr[AW+1:2];

`ifdef BUS_SCRATCH_SLV_DROP_CNT_EN
   logic [31:0] drop_cnt_q;
   logic        drop_clr, drop_evt;

   assign drop_clr = wr_hit && wr_csr && (wr_idx == AW'(4));
   assign drop_evt = rd_hit && (state_q != IDLE);

   // a clear in the same cycle as a drop leaves the counter at zero
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn)
         drop_cnt_q <= '0;
      else if (drop_clr)
         drop_cnt_q <= '0;
      else if (drop_evt)
         drop_cnt_q <= drop_cnt_q + 32'd1;
   end
`endif

   always_comb begin
      csr_rd = '0;
      if (rd_idx == AW'(0))
         csr_rd = {28'd0, wait_q};
      else if (rd_idx == AW'(1))
         csr_rd = wr_cnt_q;
      else if (rd_idx == AW'(2))
         csr_rd = rd_cnt_q;
      else if (rd_idx == AW'(3))
         csr_rd = ID_VAL;
`ifdef BUS_SCRATCH_SLV_DROP_CNT_EN
      else if (rd_idx == AW'(4))
         csr_rd = drop_cnt_q;
`endif
   end

   // combinational read sees pre-edge contents, so a same-cycle write to the
   // same word returns the old data
   assign rd_val = rd_csr ? csr_rd : mem[rd_idx];

   always_ff @(posedge clk) begin
      if (wr_hit && !wr_csr)
         mem[wr_idx] <= axi_mst_wr_data;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         wait_q   <= WAIT_RST;
         wr_cnt_q <= '0;
      end else if (wr_hit) begin
         if (!wr_csr)
            wr_cnt_q <= wr_cnt_q + 32'd1;
         else if (wr_idx == AW'(0))
            wait_q <= axi_mst_wr_data[3:0];
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         hold_q             <= '0;
         rd_cnt_q           <= '0;
         c_axi_slv_rd_ready <= 1'b0;
         axi_slv_rd_data    <= '0;
         c_busy             <= 1'b0;
      end else begin
         c_axi_slv_rd_ready <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rd_hit) begin
                  hold_q <= rd_val;
                  cnt_q  <= wait_q;
                  c_busy <= 1'b1;
                  if (wait_q == 4'd0) begin
                     state_q            <= RESP;
                     c_axi_slv_rd_ready <= 1'b1;
                     axi_slv_rd_data    <= rd_val;
                  end else begin
                     state_q <= WAITING;
                  end
               end
            end
            WAITING: begin
               if (cnt_q == 4'd1) begin
                  state_q            <= RESP;
                  c_axi_slv_rd_ready <= 1'b1;
                  axi_slv_rd_data    <= hold_q;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               state_q  <= IDLE;
               c_busy   <= 1'b0;
               rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_scratch_slv.sv
module tb_bus_scratch_slv;

   localparam int          DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0004_0000;
   localparam logic [31:0] CSR   = BASE + 32'h400;
   localparam logic [31:0] IDV   = 32'h5C7A_0001;

   logic        clk, arstn;
   logic        wr_valid, rd_valid;
   logic [31:0] wr_addr, wr_data, rd_addr;
   logic        rd_ready, busy;
   logic [31:0] rd_data;

   bus_scratch_slv dut (
      .clk                (clk),
      .arstn              (arstn),
      .c_axi_mst_wr_valid (wr_valid),
      .axi_mst_wr_addr    (wr_addr),
      .axi_mst_wr_data    (wr_data),
      .c_axi_mst_rd_valid (rd_valid),
      .axi_mst_rd_addr    (rd_addr),
      .c_axi_slv_rd_ready (rd_ready),
      .axi_slv_rd_data    (rd_data),
      .c_busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] mem_m [DEPTH];
   bit          mem_v [DEPTH];
   int unsigned wait_m, wr_cnt_m, rd_cnt_m, drop_m;

   function automatic void decode(input logic [31:0] a, output bit hit, output bit csr, output int idx);
      longint off;
      off = longint'(a) - longint'(BASE);
      hit = (off >= 0) && (off < longint'(2 * DEPTH * 4));
      csr = 1'b0;
      idx = 0;
      if (hit) begin
         idx = int'((off / 4) % DEPTH);
         csr = (off / 4) >= DEPTH;
      end
   endfunction

   function automatic void model_wr(input logic [31:0] a, input logic [31:0] d);
      bit hit, csr;
      int idx;
      decode(a, hit, csr, idx);
      if (!hit) return;
      if (!csr) begin
         mem_m[idx] = d;
         mem_v[idx] = 1'b1;
         wr_cnt_m++;
      end else if (idx == 0) begin
         wait_m = d % 16;
      end
`ifdef BUS_SCRATCH_SLV_DROP_CNT_EN
      else if (idx == 4) drop_m = 0;
`endif
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      bit hit, csr;
      int idx;
      decode(a, hit, csr, idx);
      if (!csr) return mem_m[idx];
      case (idx)
         0: return 32'(wait_m);
         1: return 32'(wr_cnt_m);
         2: return 32'(rd_cnt_m);
         3: return IDV;
`ifdef BUS_SCRATCH_SLV_DROP_CNT_EN
         4: return 32'(drop_m);
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic drive_wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      model_wr(a, d);
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // waits for the strobe; lat counts negedges after the request negedge, -1 on timeout
   task automatic wait_resp(output logic [31:0] got, output int lat);
      lat = -1;
      got = '0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         rd_valid = 1'b0;
         wr_valid = 1'b0;
         if (rd_ready === 1'b1) begin
            got = rd_data;
            lat = n;
            break;
         end
      end
   endtask

   task automatic rd_txn(input logic [31:0] a, output logic [31:0] got, output int lat);
      bit hit, csr;
      int idx;
      decode(a, hit, csr, idx);
      @(negedge clk);
      rd_valid = 1'b1; rd_addr = a;
      if (hit) rd_cnt_m++;
      wait_resp(got, lat);
   endtask

   task automatic test_reset();
      logic [31:0] got;
      int lat;
      arstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (rd_ready !== 1'b0 || busy !== 1'b0 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b busy=%b data=%h, want 0 0 0", rd_ready, busy, rd_data);
      end
      arstn = 1'b1;
      wait_m = 1; wr_cnt_m = 0; rd_cnt_m = 0; drop_m = 0;
      rd_txn(CSR + 32'd12, got, lat);
      checks++;
      if (got !== IDV || lat != 2) begin
         errors++;
         $display("FAIL reset_id: data=%h lat=%0d, want %h lat=2", got, lat, IDV);
      end
      rd_txn(CSR, got, lat);
      checks++;
      if (got !== 32'h1 || lat != 2) begin
         errors++;
         $display("FAIL reset_wait: data=%h lat=%0d, want 1 lat=2", got, lat);
      end
   endtask

   task automatic test_ram_rw();
      logic [31:0] got, exp;
      int lat;
      drive_wr(BASE + 32'h10, 32'hA5A5_0001);
      exp = model_rd(BASE + 32'h10);
      rd_txn(BASE + 32'h10, got, lat);
      checks++;
      if (got !== exp || lat != int'(wait_m) + 1) begin
         errors++;
         $display("FAIL ram_read: data=%h lat=%0d, want %h lat=%0d", got, lat, exp, wait_m + 1);
      end
      @(negedge clk);
      checks++;
      if (rd_ready !== 1'b0 || rd_data !== exp) begin
         errors++;
         $display("FAIL strobe_hold: ready=%b data=%h, want 0 %h", rd_ready, rd_data, exp);
      end
      drive_wr(BASE + 32'h17, 32'h1234_5678);
      exp = model_rd(BASE + 32'h14);
      rd_txn(BASE + 32'h14, got, lat);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL ram_lsb_ignored: data=%h, want %h", got, exp);
      end
      exp = model_rd(CSR + 32'd4);
      rd_txn(CSR + 32'd4, got, lat);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL wr_cnt: data=%h, want %h", got, exp);
      end
      exp = model_rd(CSR + 32'd8);
      rd_txn(CSR + 32'd8, got, lat);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL rd_cnt: data=%h, want %h", got, exp);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] got, exp;
      int lat;
      drive_wr(CSR, 32'h0);
      exp = model_rd(BASE + 32'h10);
      rd_txn(BASE + 32'h10, got, lat);
      checks++;
      if (got !== exp || lat != 1) begin
         errors++;
         $display("FAIL wait0: data=%h lat=%0d, want %h lat=1", got, lat, exp);
      end
      drive_wr(BASE + 32'd20, 32'hCAFE_0005);
      drive_wr(CSR, 32'hFFFF_FFFF);
      exp = model_rd(BASE + 32'd20);
      @(negedge clk);
      rd_valid = 1'b1; rd_addr = BASE + 32'd20;
      rd_cnt_m++;
      lat = -1;
      for (int n = 1; n <= 36; n++) begin
         @(negedge clk);
         rd_valid = 1'b0;
         wr_valid = 1'b0;
         if (rd_ready === 1'b1) begin
            if (lat < 0) begin
               lat = n;
               checks++;
               if (rd_data !== exp) begin
                  errors++;
                  $display("FAIL wait15_data: data=%h, want %h", rd_data, exp);
               end
            end else begin
               checks++;
               errors++;
               $display("FAIL dropped_read_answered: strobe at %0d, want none", n);
            end
         end else if (n < 16) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL wait15_busy: busy=%b at %0d, want 1", busy, n);
            end
         end
         if (n == 4) begin
            rd_valid = 1'b1; rd_addr = BASE + 32'd24;
`ifdef BUS_SCRATCH_SLV_DROP_CNT_EN
            drop_m++;
`endif
            wr_valid = 1'b1; wr_addr = CSR; wr_data = 32'h0;
            model_wr(CSR, 32'h0);
         end
         if (n == 6) begin
            wr_valid = 1'b1; wr_addr = BASE + 32'd28; wr_data = 32'h0BAD_F00D;
            model_wr(BASE + 32'd28, 32'h0BAD_F00D);
         end
      end
      checks++;
      if (lat != 16) begin
         errors++;
         $display("FAIL wait15_latency: lat=%0d, want 16", lat);
      end
      exp = model_rd(BASE + 32'd28);
      rd_txn(BASE + 32'd28, got, lat);
      checks++;
      if (got !== exp || lat != 1) begin
         errors++;
         $display("FAIL write_while_busy: data=%h lat=%0d, want %h lat=1", got, lat, exp);
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] got, exp;
      int lat;
      drive_wr(BASE + 32'd40, 32'h1);
      @(negedge clk);
      exp = model_rd(BASE + 32'd40);
      rd_valid = 1'b1; rd_addr = BASE + 32'd40;
      wr_valid = 1'b1; wr_addr = BASE + 32'd40; wr_data = 32'h2;
      rd_cnt_m++;
      model_wr(BASE + 32'd40, 32'h2);
      wait_resp(got, lat);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL same_cycle_old: data=%h, want %h", got, exp);
      end
      exp = model_rd(BASE + 32'd40);
      rd_txn(BASE + 32'd40, got, lat);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL same_cycle_new: data=%h, want %h", got, exp);
      end
   endtask

   task automatic test_decode_miss();
      logic [31:0] got, exp;
      int lat;
      rd_txn(BASE + 32'h2000, got, lat);
      checks++;
      if (lat != -1) begin
         errors++;
         $display("FAIL miss_no_strobe: strobe at %0d, want none", lat);
      end
      drive_wr(BASE + 32'h2000, 32'h0);
      drive_wr(BASE - 32'd4, 32'h0);
      drive_wr(CSR + 32'd4, 32'hDEAD_BEEF);
      drive_wr(CSR + 32'd20, 32'hDEAD_BEEF);
      for (int k = 1; k <= 5; k++) begin
         exp = model_rd(CSR + 32'(4 * k));
         rd_txn(CSR + 32'(4 * k), got, lat);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL miss_csr%0d: data=%h, want %h", k, got, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d, got, exp;
      int lat, idx, elat;
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0, 1: begin
               idx = $urandom_range(0, 31);
               a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
               d = $urandom;
               drive_wr(a, d);
            end
            2: drive_wr(CSR, {$urandom_range(0, 15)} & 32'h0000_FFF3);
            default: begin
               idx = $urandom_range(0, 31);
               if (mem_v[idx]) a = BASE + 32'(idx * 4);
               else a = CSR + 32'(4 * $urandom_range(0, 5));
               exp = model_rd(a);
               elat = int'(wait_m) + 1;
               rd_txn(a, got, lat);
               checks++;
               if (got !== exp || lat != elat) begin
                  errors++;
                  $display("FAIL random_read %h: data=%h lat=%0d, want %h lat=%0d", a, got, lat, exp, elat);
               end
            end
         endcase
      end
   endtask

`ifdef BUS_SCRATCH_SLV_DROP_CNT_EN
   task automatic test_drop_cnt();
      logic [31:0] got, exp;
      int lat;
      drive_wr(CSR + 32'd16, 32'h0);
      drive_wr(CSR, 32'd10);
      @(negedge clk);
      rd_valid = 1'b1; rd_addr = CSR + 32'd12;
      rd_cnt_m++;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         rd_valid = 1'b1; rd_addr = CSR + 32'd12;
         drop_m++;
      end
      wait_resp(got, lat);
      exp = model_rd(CSR + 32'd16);
      rd_txn(CSR + 32'd16, got, lat);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL drop_cnt: data=%h, want %h", got, exp);
      end
      @(negedge clk);
      rd_valid = 1'b1; rd_addr = CSR + 32'd12;
      rd_cnt_m++;
      @(negedge clk);
      rd_valid = 1'b1; rd_addr = CSR + 32'd12;
      wr_valid = 1'b1; wr_addr = CSR + 32'd16; wr_data = 32'h5;
      drop_m++;
      model_wr(CSR + 32'd16, 32'h5);
      wait_resp(got, lat);
      exp = model_rd(CSR + 32'd16);
      rd_txn(CSR + 32'd16, got, lat);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL drop_clear_wins: data=%h, want %h", got, exp);
      end
   endtask
`endif

   task automatic test_reset_mid_read();
      logic [31:0] got;
      int lat;
      drive_wr(CSR, 32'd8);
      @(negedge clk);
      rd_valid = 1'b1; rd_addr = CSR + 32'd12;
      @(negedge clk);
      rd_valid = 1'b0;
      repeat (3) @(negedge clk);
      arstn = 1'b0;
      @(negedge clk);
      arstn = 1'b1;
      wait_m = 1; wr_cnt_m = 0; rd_cnt_m = 0; drop_m = 0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_busy: busy=%b, want 0", busy);
      end
      wait_resp(got, lat);
      checks++;
      if (lat != -1) begin
         errors++;
         $display("FAIL midreset_no_strobe: strobe at %0d, want none", lat);
      end
      rd_txn(CSR, got, lat);
      checks++;
      if (got !== 32'h1 || lat != 2) begin
         errors++;
         $display("FAIL midreset_wait: data=%h lat=%0d, want 1 lat=2", got, lat);
      end
   endtask

   initial begin
      arstn = 1'b0;
      wr_valid = 1'b0; rd_valid = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
      for (int i = 0; i < DEPTH; i++) mem_v[i] = 1'b0;
      test_reset();
      test_ram_rw();
      test_wait_states();
      test_same_cycle();
      test_decode_miss();
      test_random();
`ifdef BUS_SCRATCH_SLV_DROP_CNT_EN
      test_drop_cnt();
`endif
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
